// File: rtl/wbm_cmd_master.sv
// ============================================================================
// Module   : wbm_cmd_master
// Brief    : Command/response to Wishbone classic master bridge with ack timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wbm_cmd_master #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = BUS;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cnt_d   = '0;
        end
      end
      BUS: begin
        // Ack wins over a timeout landing on the same edge.
        if (wbm_ack_i) begin
          state_d   = RESP;
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
        end else if (cnt_q == c_cnt_last) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
          rsp_dat_d = ERR_DATA;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is a pure state decode, masked while reset is held.
  assign cmd_ready = (state_q == IDLE) && !wb_rst_i;
  assign rsp_valid = (state_q == RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = (state_q == BUS);
  assign wbm_stb_o = (state_q == BUS);
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wbm_cmd_master.sv
// ============================================================================
// Module   : tb_wbm_cmd_master
// Brief    : Scoreboard bench for wbm_cmd_master (read/write/timeout/reset).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wbm_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        ack;
  logic [31:0] dat_i;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_err_cnt = 0;

  always #5 clk = ~clk;

  wbm_cmd_master #(.TIMEOUT(64), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_ack_i(ack),
    .wbm_dat_i(dat_i),
    .err_cnt  (err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns in the first cycle after the accepting edge.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) begin
      errors++; checks++;
      $display("FAIL cmd_accept: cmd_ready=%0b, required 1 within 200 cycles", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] d, output logic e, output bit got);
    int n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    got = rsp_valid; d = rsp_dat; e = rsp_err;
    if (got) begin
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b, need 0", cmd_ready); end
    checks++;
    if ({cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_err, rsp_dat, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cyc=%0b stb=%0b we=%0b sel=%h adr=%h dat=%h rv=%0b re=%0b rd=%h ec=%0d, need all 0",
               cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_err, rsp_dat, err_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b, need 1", cmd_ready); end
    exp_err_cnt = 0;
  endtask

  task automatic test_read();
    logic [31:0] d; logic e; bit got; rsp_t x;
    send_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    exp_q.push_back('{32'h1234_5678, 1'b0});
    checks++;
    if (!(cyc === 1'b1 && stb === 1'b1 && we === 1'b0 && adr === 32'h3000_0004 && sel === 4'hF)) begin
      errors++; $display("FAIL read_bus: cyc=%0b stb=%0b we=%0b adr=%h sel=%h, need 1 1 0 30000004 f", cyc, stb, we, adr, sel);
    end
    repeat (2) tick();
    ack = 1'b1; dat_i = 32'h1234_5678;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    checks++;
    if (cyc !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL read_after_ack: cyc=%0b rsp_valid=%0b, need 0 1", cyc, rsp_valid);
    end
    collect(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (!got || d !== x.dat || e !== x.err) begin
      errors++; $display("FAIL read_rsp: got=%0b dat=%h err=%0b, need dat=%h err=%0b", got, d, e, x.dat, x.err);
    end
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL read_post_hs: rsp_valid=%0b cmd_ready=%0b, need 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write();
    logic [31:0] d; logic e; bit got; rsp_t x;
    send_cmd(1'b1, 32'h3000_0000, 32'hA5A5_0001, 4'h3);
    exp_q.push_back('{32'h0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!(stb === 1'b1 && we === 1'b1 && adr === 32'h3000_0000 && dat_o === 32'hA5A5_0001 && sel === 4'h3)) begin
        errors++; $display("FAIL write_bus[%0d]: stb=%0b we=%0b adr=%h dat=%h sel=%h", i, stb, we, adr, dat_o, sel);
      end
      if (i < 3) tick();
    end
    ack = 1'b1; dat_i = 32'hFFFF_FFFF;
    tick();
    ack = 1'b0;
    collect(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (!got || d !== x.dat || e !== x.err) begin
      errors++; $display("FAIL write_rsp: got=%0b dat=%h err=%0b, need dat=%h err=%0b", got, d, e, x.dat, x.err);
    end
    checks++;
    if (cyc !== 1'b0 || adr !== 32'h3000_0000 || we !== 1'b1 || dat_o !== 32'hA5A5_0001) begin
      errors++; $display("FAIL write_retain: cyc=%0b adr=%h we=%0b dat=%h", cyc, adr, we, dat_o);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d; logic e; bit got; rsp_t x; int n = 0;
    send_cmd(1'b0, 32'h4000_0010, 32'h0, 4'hF);
    exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
    exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
    while (stb && n < 300) begin n++; tick(); end
    checks++;
    if (n != 64) begin errors++; $display("FAIL timeout_stb_len: got %0d cycles, need 64", n); end
    collect(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (!got || d !== x.dat || e !== x.err) begin
      errors++; $display("FAIL timeout_rsp: got=%0b dat=%h err=%0b, need dat=%h err=%0b", got, d, e, x.dat, x.err);
    end
    checks++;
    if (err_cnt !== 8'(exp_err_cnt)) begin
      errors++; $display("FAIL timeout_err_cnt: got %0d, need %0d", err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_ack_boundary();
    logic [31:0] d; logic e; bit got; rsp_t x;
    send_cmd(1'b0, 32'h5000_0000, 32'h0, 4'hF);
    exp_q.push_back('{32'hCAFE_F00D, 1'b0});
    repeat (63) tick();
    checks++;
    if (stb !== 1'b1) begin errors++; $display("FAIL boundary_stb: got %0b, need 1 at counter=63", stb); end
    ack = 1'b1; dat_i = 32'hCAFE_F00D;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    collect(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (!got || d !== x.dat || e !== x.err) begin
      errors++; $display("FAIL boundary_rsp: got=%0b dat=%h err=%0b, need dat=%h err=%0b", got, d, e, x.dat, x.err);
    end
    checks++;
    if (err_cnt !== 8'(exp_err_cnt)) begin
      errors++; $display("FAIL boundary_err_cnt: got %0d, need %0d", err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_stray_ack();
    ack = 1'b1; dat_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || cyc !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL stray_ack[%0d]: rsp_valid=%0b cyc=%0b cmd_ready=%0b, need 0 0 1", i, rsp_valid, cyc, cmd_ready);
      end
    end
    ack = 1'b0; dat_i = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; bit got; rsp_t x;
    send_cmd(1'b0, 32'h6000_0000, 32'h0, 4'h1);
    exp_q.push_back('{32'h0BAD_F00D, 1'b0});
    ack = 1'b1; dat_i = 32'h0BAD_F00D;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h6000_0008; cmd_dat = 32'h1111_2222; cmd_sel = 4'hC;
    x = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== x.dat || rsp_err !== x.err || cmd_ready !== 1'b0 || cyc !== 1'b0) begin
        errors++; $display("FAIL backpressure[%0d]: rv=%0b rd=%h re=%0b cr=%0b cyc=%0b, need 1 %h %0b 0 0",
                           i, rsp_valid, rsp_dat, rsp_err, cmd_ready, cyc, x.dat, x.err);
      end
      tick();
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: cmd_ready=%0b rsp_valid=%0b, need 1 0", cmd_ready, rsp_valid);
    end
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back('{32'h0, 1'b0});
    checks++;
    if (stb !== 1'b1 || adr !== 32'h6000_0008 || sel !== 4'hC || dat_o !== 32'h1111_2222) begin
      errors++; $display("FAIL b2b_bus: stb=%0b adr=%h sel=%h dat=%h", stb, adr, sel, dat_o);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    collect(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (!got || d !== x.dat || e !== x.err) begin
      errors++; $display("FAIL b2b_rsp: got=%0b dat=%h err=%0b, need dat=%h err=%0b", got, d, e, x.dat, x.err);
    end
  endtask

  task automatic test_reset_mid_bus();
    bit seen = 1'b0;
    send_cmd(1'b1, 32'h7000_0000, 32'h5555_AAAA, 4'hF);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (cyc !== 1'b0 || stb !== 1'b0 || adr !== 32'h0 || cmd_ready !== 1'b0 || err_cnt !== 8'h0) begin
      errors++; $display("FAIL midbus_reset: cyc=%0b stb=%0b adr=%h cmd_ready=%0b err_cnt=%0d, need 0 0 0 0 0",
                         cyc, stb, adr, cmd_ready, err_cnt);
    end
    rst = 1'b0;
    exp_err_cnt = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midbus_release_ready: got %0b, need 1", cmd_ready); end
    ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    ack = 1'b0;
    checks++;
    if (seen || rsp_valid !== 1'b0) begin errors++; $display("FAIL midbus_no_rsp: rsp_valid seen=%0b, need 0", seen); end
  endtask

  task automatic test_err_saturation();
    logic [31:0] d; logic e; bit got; rsp_t x; int bad = 0;
    for (int i = 0; i < 300; i++) begin
      send_cmd(1'b0, 32'h8000_0000 + 32'(i), 32'h0, 4'hF);
      exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
      exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
      collect(d, e, got);
      x = exp_q.pop_front();
      checks++;
      if (!got || d !== x.dat || e !== x.err || err_cnt !== 8'(exp_err_cnt)) begin
        errors++;
        if (bad < 5) $display("FAIL sat_rsp[%0d]: got=%0b dat=%h err=%0b cnt=%0d, need %h %0b %0d",
                              i, got, d, e, err_cnt, x.dat, x.err, exp_err_cnt);
        bad++;
      end
    end
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: err_cnt=%0d, need 255", err_cnt); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
    tick();
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_boundary();
    test_stray_ack();
    test_back_to_back();
    test_reset_mid_bus();
    test_err_saturation();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: %0d left, need 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/wbm_cmd_master.md
WBM_CMD_MASTER -- requirements
Module: wbm_cmd_master

Interface
REQ-001 Parameter: TIMEOUT, default 64, bus cycles allowed from stb assertion to ack before abort (legal range 2..255).
REQ-002 Parameter: ERR_DATA, default 32'hDEAD_BEEF, rsp_dat value returned on timeout.
REQ-003 Port: wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 Port: wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid  in  1  command present.
REQ-006 Port: cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clock edge.
REQ-007 Port: cmd_we  in  1  1=write, 0=read.
REQ-008 Port: cmd_adr  in  32  byte address.
REQ-009 Port: cmd_dat  in  32  write data.
REQ-010 Port: cmd_sel  in  4  byte lane select.
REQ-011 Port: rsp_valid  out  1  response present.
REQ-012 Port: rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high on a clock edge.
REQ-013 Port: rsp_dat  out  32  read data; 0 for writes; ERR_DATA on timeout.
REQ-014 Port: rsp_err  out  1  1 = transaction timed out.
REQ-015 Port: wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
REQ-016 Port: wbm_sel_o  out  4;  wbm_adr_o  out  32;  wbm_dat_o  out  32  Wishbone master fields.
REQ-017 Port: wbm_ack_i  in  1;  wbm_dat_i  in  32  Wishbone slave acknowledge and read data.
REQ-018 Port: err_cnt  out  8  saturating timeout count.

Function
REQ-019 FSM SHALL have exactly three states: IDLE, BUS, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; it is a registered state decode, not a function of cmd_valid.
REQ-021 IDLE + command handshake SHALL cause the following, effective the next cycle: state BUS; cyc=stb=1; we/sel/adr/dat registered from cmd_*; timeout counter cleared to 0.
REQ-022 In BUS, all wbm_* outputs SHALL stay stable until ack or timeout; counter increments by 1 each cycle without ack.
REQ-023 wbm_ack_i high in BUS SHALL cause the following, effective the next cycle: cyc=stb=0; state RESP; rsp_valid=1; rsp_err=0; rsp_dat=wbm_dat_i for reads (captured on the ack edge) and 0 for writes.
REQ-024 Counter reaching TIMEOUT-1 with no ack SHALL cause the following, effective the next cycle: cyc=stb=0; state RESP; rsp_valid=1; rsp_err=1; rsp_dat=ERR_DATA; err_cnt+1, saturating at 255.
REQ-025 Ack on the same cycle as the timeout condition SHALL be treated as success.
REQ-026 wbm_ack_i outside BUS SHALL be ignored, with no state or output change.
REQ-027 In RESP, rsp_valid/rsp_dat/rsp_err SHALL hold until the response handshake; after the handshake: state IDLE, rsp_valid=0.
REQ-028 Latency: command accepted at edge 0 -> stb high in cycle 1; ack at edge k -> rsp_valid high in cycle k+1; minimum 1 cycle with cmd_ready=1 between transactions.
REQ-029 wbm_we_o/sel/adr/dat SHALL retain their last values when cyc=0; only cyc/stb qualify the bus.

Reset
REQ-030 wb_rst_i high at an edge SHALL force the following, in any state including mid-BUS or RESP: state IDLE; cyc=stb=we=0; sel=0; adr=0; dat=0; rsp_valid=0; rsp_err=0; rsp_dat=0; err_cnt=0; counter=0.
REQ-031 cmd_ready SHALL be 0 while wb_rst_i is high and 1 in the first cycle after release.
REQ-032 A transaction aborted by reset SHALL produce no response.

Verification
REQ-033 Read: cmd adr=32'h3000_0004, sel=4'hF; slave acks 3 cycles after stb with dat=32'h1234_5678 -> rsp_valid, rsp_dat=32'h1234_5678, rsp_err=0; cyc low the cycle after ack.
REQ-034 Write: cmd we=1, adr=32'h3000_0000, dat=32'hA5A5_0001, sel=4'h3 -> bus shows exactly those fields until ack; rsp_dat=0, rsp_err=0.
REQ-035 Timeout: no ack, TIMEOUT=64 -> stb high for exactly 64 cycles, then rsp_err=1, rsp_dat=32'hDEAD_BEEF, err_cnt=1; 300 timeouts -> err_cnt=255.
REQ-036 Backpressure: rsp_ready=0 for 10 cycles -> response stable; cmd_ready=0 and no new cyc throughout; cmd_ready=1 the cycle after the response handshake.
REQ-037 Boundary: ack at counter=TIMEOUT-1 -> success response; stray ack in IDLE -> no response.
REQ-038 Reset mid-BUS -> cyc=0 the next cycle, rsp_valid never asserted, cmd_ready=1 after release.
